// File: rtl/coef_readback_tx.sv
// coef_readback_tx: mode-0 SPI slave returning the live coefficient set.
// Optional CRC-16-CCITT trailer when COEF_READBACK_CRC_EN is defined.
module coef_readback_tx #(
  parameter int          FRAME_BITS  = 336,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] MAGIC       = 16'hC0EF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sck,
  input  logic         cs_n,
  input  logic [239:0] coef_bus,
  output logic         miso,
  output logic         miso_oe,
  output logic         busy,
  output logic         frame_done,
  output logic         frame_abort
);

`ifdef COEF_READBACK_CRC_EN
  localparam int TOTAL = FRAME_BITS + 16;
`else
  localparam int TOTAL = FRAME_BITS;
`endif
  localparam int CW  = $clog2(FRAME_BITS + 17);
  localparam int PAD = FRAME_BITS - 256;
  localparam logic [CW-1:0] FLUSH = CW'(SYNC_STAGES + 1);
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] PAYLD = CW'(FRAME_BITS);

  typedef enum logic [1:0] {
    WAIT_HI,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync;
  logic                   sck_h, cs_h;
  logic                   sck_s, cs_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-2:0] shreg_q, shreg_d;
  logic                miso_q, miso_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic [FRAME_BITS-1:0] frame;
`ifdef COEF_READBACK_CRC_EN
  logic [15:0]         crc_q, crc_d;
  logic                crc_fb;
`endif

  assign frame = {MAGIC, {PAD{1'b0}}, coef_bus};

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_h;
  assign sck_fall = ~sck_s & sck_h;
  assign cs_rise  = cs_s & ~cs_h;
  assign cs_fall  = ~cs_s & cs_h;

  // Synchronisers plus history flops for the asynchronous SPI pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '1;
      cs_sync  <= '1;
      sck_h    <= 1'b1;
      cs_h     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_h    <= sck_s;
      cs_h     <= cs_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_HI;
      cnt_q   <= '0;
      shreg_q <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef COEF_READBACK_CRC_EN
      crc_q   <= '1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
`ifdef COEF_READBACK_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  // Next-state and datapath update; WAIT_HI uses cnt to let the
  // synchronisers flush their reset value before trusting cs_n.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
`ifdef COEF_READBACK_CRC_EN
    crc_d   = crc_q;
    crc_fb  = crc_q[15] ^ miso_q;
`endif
    unique case (state_q)
      WAIT_HI: begin
        if (cnt_q < FLUSH) begin
          cnt_d = cnt_q + 1'b1;
        end else if (cs_s && cs_h) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          shreg_d = frame[FRAME_BITS-2:0];
          miso_d  = frame[FRAME_BITS-1];
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
`ifdef COEF_READBACK_CRC_EN
          crc_d   = '1;
`endif
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          abort_d = 1'b1;
        end else if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
`ifdef COEF_READBACK_CRC_EN
          if (cnt_q < PAYLD)
            crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
          if (cnt_q == LAST) begin
            state_d = DONE;
            miso_d  = 1'b0;
          end
        end else if (sck_fall) begin
          if (cnt_q < PAYLD) begin
            miso_d  = shreg_q[FRAME_BITS-2];
            shreg_d = {shreg_q[FRAME_BITS-3:0], 1'b0};
          end
`ifdef COEF_READBACK_CRC_EN
          else begin
            miso_d = crc_q[15];
            crc_d  = {crc_q[14:0], 1'b0};
          end
`endif
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  assign miso        = miso_q;
  assign miso_oe     = oe_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_coef_readback_tx.sv
// tb_coef_readback_tx: drives SPI frames and checks against a frame model.
// Model: expected bit k of a frame is derived from the cs_n-fall snapshot.
module tb_coef_readback_tx;

  localparam int FB   = 336;
  localparam int HALF = 4;
`ifdef COEF_READBACK_CRC_EN
  localparam int TOTAL = FB + 16;
`else
  localparam int TOTAL = FB;
`endif
  localparam int P_NONE = 0;
  localparam int P_ACT  = 1;
  localparam int P_IDLE = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sck = 1'b0;
  logic         cs_n = 1'b1;
  logic [239:0] coef_bus = '0;
  logic         miso, miso_oe, busy, frame_done, frame_abort;

  int checks = 0;
  int errors = 0;
  int phase  = P_NONE;
  logic rx [0:399];

  coef_readback_tx dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .cs_n       (cs_n),
    .coef_bus   (coef_bus),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [FB-1:0] fr);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = FB - 1; i >= 0; i--) begin
      fb = c[15] ^ fr[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic exp_bit(input logic [FB-1:0] fr,
                                   input logic [15:0] crc, input int k);
    if (k < FB) return fr[FB-1-k];
    if (k < TOTAL) return crc[15-(k-FB)];
    return 1'b0;
  endfunction

  function automatic logic [239:0] rnd_coef();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[239:0];
  endfunction

  // Per-cycle check of the handshake outputs against the expected phase.
  always @(posedge clk) begin
    #1;
    if (phase == P_ACT)
      chk("active_outs", 32'({miso_oe, busy, frame_done, frame_abort}),
          32'h0000_000C);
    else if (phase == P_IDLE)
      chk("idle_outs",
          32'({miso, miso_oe, busy, frame_done, frame_abort}), 32'h0);
  end

  task automatic send_bits(input int n, input int first, input bit do_chk,
                           input logic [FB-1:0] fr, input logic [15:0] crc,
                           input int change_at, input logic [239:0] newc);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = first + k;
      repeat (HALF) @(negedge clk);
      if (idx < 400) rx[idx] = miso;
      if (do_chk) chk($sformatf("bit%0d", idx), 32'(miso),
                      32'(exp_bit(fr, crc, idx)));
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      if (idx + 1 == change_at) coef_bus = newc;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic release_cs(input bit exp_done);
    int nd, na;
    nd = 0;
    na = 0;
    @(negedge clk);
    phase = P_NONE;
    cs_n  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (frame_done || frame_abort)
        chk("oe_at_pulse", 32'({miso_oe, busy}), 32'h0);
      nd += int'(frame_done);
      na += int'(frame_abort);
    end
    chk("done_cnt", 32'(nd), 32'(exp_done));
    chk("abort_cnt", 32'(na), 32'(!exp_done));
    phase = P_IDLE;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_frame(output logic [FB-1:0] fr,
                             output logic [15:0] crc);
    @(negedge clk);
    fr    = {16'hC0EF, 80'h0, coef_bus};
    crc   = crc16(fr);
    phase = P_NONE;
    cs_n  = 1'b0;
    repeat (6) @(negedge clk);
    phase = P_ACT;
  endtask

  task automatic frame(input int nsck, input int change_at,
                       input logic [239:0] newc);
    logic [FB-1:0] fr;
    logic [15:0]   crc;
    start_frame(fr, crc);
    send_bits(nsck, 0, 1'b1, fr, crc, change_at, newc);
    release_cs(nsck >= TOTAL);
  endtask

  initial begin
    logic [15:0]   w;
    logic [FB-1:0] fr;
    logic [15:0]   crc;
    int            kind, n;

    repeat (3) @(negedge clk);
    chk("reset_outs",
        32'({miso, miso_oe, busy, frame_done, frame_abort}), 32'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    phase = P_IDLE;
    repeat (4) @(negedge clk);

    // Full frame, b0 = 0x4000 in every band.
    coef_bus = '0;
    coef_bus[239:224] = 16'h4000;
    coef_bus[159:144] = 16'h4000;
    coef_bus[79:64]   = 16'h4000;
    frame(TOTAL, 0, '0);
    w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], rx[i]};
    chk("magic_word", 32'(w), 32'h0000_C0EF);
    chk("low_b0_b14", 32'(rx[97]), 32'h1);
    chk("low_b0_b15", 32'(rx[96]), 32'h0);
    chk("mid_b0_b14", 32'(rx[177]), 32'h1);
    chk("high_b0_b14", 32'(rx[257]), 32'h1);

    // Coefficients change mid-frame; snapshot must hold.
    frame(TOTAL, 100, {240{1'b1}});
    chk("snap_bit150", 32'(rx[150]), 32'h0);

    // Abort after 200 sck, then a clean frame.
    coef_bus = rnd_coef();
    frame(200, 0, '0);
    frame(TOTAL, 0, '0);

    // Reset mid-frame with cs_n held low.
    start_frame(fr, crc);
    send_bits(150, 0, 1'b1, fr, crc, 0, '0);
    @(negedge clk);
    phase = P_NONE;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    phase = P_IDLE;
    send_bits(FB, 0, 1'b0, fr, crc, 0, '0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    coef_bus = rnd_coef();
    frame(TOTAL, 0, '0);

    // Over-clocked frame: trailing bits read zero.
    frame(TOTAL + 4, 0, '0);
    chk("over_bit_last", 32'(rx[TOTAL+3]), 32'h0);

    // Randomised frames.
    for (int r = 0; r < 8; r++) begin
      coef_bus = rnd_coef();
      kind = $urandom_range(0, 2);
      if (kind == 0) n = TOTAL;
      else if (kind == 1) n = TOTAL + $urandom_range(1, 6);
      else n = $urandom_range(1, TOTAL - 1);
      frame(n, $urandom_range(1, 300), rnd_coef());
    end

    phase = P_NONE;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
